// File: rtl/mac_sequencer.sv
// Sequencer for the 3x3 convolution MAC pipeline: raster-order window fetches, credit-based
// flow control, and delay pipes that tag each MAC result with its output position.
module mac_sequencer #(
    parameter int unsigned WID_DIM    = 10,
    parameter int unsigned FETCH_LAT  = 1,
    parameter int unsigned MAC_STAGES = 3,
    parameter int unsigned CREDITS    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WID_DIM-1:0] cfg_width,
    input  logic [WID_DIM-1:0] cfg_height,
    input  logic               credit_return,
    output logic               fetch_valid,
    output logic [WID_DIM-1:0] fetch_row,
    output logic [WID_DIM-1:0] fetch_col,
    output logic               mac_enable,
    output logic               out_valid,
    output logic [WID_DIM-1:0] out_row,
    output logic [WID_DIM-1:0] out_col,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               credit_err
);

    localparam int unsigned L  = FETCH_LAT + MAC_STAGES;
    localparam int unsigned CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]      CMax   = CW'(CREDITS);
    localparam logic [WID_DIM-1:0] MinDim = WID_DIM'(3);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q;
    logic [WID_DIM-1:0] row_q, col_q;
    // Last valid coordinate (OW-1, OH-1); width-3 cannot overflow once width >= 3.
    logic [WID_DIM-1:0] ow_m1_q, oh_m1_q;
    logic [CW-1:0]      credit_q, credit_d;
    logic [L-1:0]       vld_q;
    logic [WID_DIM-1:0] row_pipe_q [L];
    logic [WID_DIM-1:0] col_pipe_q [L];
    logic               done_q, cfg_err_q, credit_err_q;
    logic               issue, last_issue, drain_done, credit_ovf;

    always_comb begin
        issue      = (state_q == StRun) && (credit_q != '0);
        last_issue = issue && (row_q == oh_m1_q) && (col_q == ow_m1_q);
        // Nothing issued remains behind the result currently on out_valid.
        drain_done = vld_q[L-1] && (vld_q[L-2:0] == '0);
        credit_d   = credit_q;
        credit_ovf = 1'b0;
        if (issue && !credit_return) begin
            credit_d = credit_q - CW'(1);
        end else if (!issue && credit_return) begin
            if (credit_q == CMax) begin
                credit_ovf = 1'b1;
            end else begin
                credit_d = credit_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            ow_m1_q      <= '0;
            oh_m1_q      <= '0;
            credit_q     <= CMax;
            vld_q        <= '0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            credit_err_q <= 1'b0;
            for (int unsigned i = 0; i < L; i++) begin
                row_pipe_q[i] <= '0;
                col_pipe_q[i] <= '0;
            end
        end else begin
            done_q   <= 1'b0;
            credit_q <= credit_d;
            if (credit_ovf) begin
                credit_err_q <= 1'b1;
            end
            vld_q         <= {vld_q[L-2:0], issue};
            row_pipe_q[0] <= fetch_row;
            col_pipe_q[0] <= fetch_col;
            for (int unsigned i = 1; i < L; i++) begin
                row_pipe_q[i] <= row_pipe_q[i-1];
                col_pipe_q[i] <= col_pipe_q[i-1];
            end
            if (abort) begin
                state_q  <= StIdle;
                credit_q <= CMax;
                vld_q    <= '0;
                for (int unsigned i = 0; i < L; i++) begin
                    row_pipe_q[i] <= '0;
                    col_pipe_q[i] <= '0;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            cfg_err_q    <= 1'b0;
                            credit_err_q <= 1'b0;
                            row_q        <= '0;
                            col_q        <= '0;
                            ow_m1_q      <= cfg_width - MinDim;
                            oh_m1_q      <= cfg_height - MinDim;
                            if (cfg_width < MinDim || cfg_height < MinDim) begin
                                cfg_err_q <= 1'b1;
                                done_q    <= 1'b1;
                            end else begin
                                state_q <= StRun;
                            end
                        end
                    end
                    StRun: begin
                        if (issue) begin
                            if (col_q == ow_m1_q) begin
                                col_q <= '0;
                                row_q <= row_q + WID_DIM'(1);
                            end else begin
                                col_q <= col_q + WID_DIM'(1);
                            end
                            if (last_issue) begin
                                state_q <= StDrain;
                            end
                        end
                    end
                    StDrain: begin
                        if (drain_done) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign fetch_valid = issue;
    assign fetch_row   = issue ? row_q : '0;
    assign fetch_col   = issue ? col_q : '0;
    assign mac_enable  = vld_q[L-2];
    assign out_valid   = vld_q[L-1];
    assign out_row     = row_pipe_q[L-1];
    assign out_col     = col_pipe_q[L-1];
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a negedge monitor scoreboards every fetch against the tagged
// result L cycles later; scenario tasks check counts, timing and error flags.
module tb_mac_sequencer;

    localparam int W  = 10;
    localparam int L  = 4;
    localparam int CR = 4;

    logic         clk = 1'b0;
    logic         rst, start, abort, auto_ret, man_ret;
    logic         credit_return;
    logic [W-1:0] cfg_width, cfg_height;
    logic         fetch_valid, mac_enable, out_valid, busy, done, cfg_err, credit_err;
    logic [W-1:0] fetch_row, fetch_col, out_row, out_col;

    mac_sequencer #(
        .WID_DIM   (W),
        .FETCH_LAT (1),
        .MAC_STAGES(3),
        .CREDITS   (CR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .credit_return(credit_return),
        .fetch_valid  (fetch_valid),
        .fetch_row    (fetch_row),
        .fetch_col    (fetch_col),
        .mac_enable   (mac_enable),
        .out_valid    (out_valid),
        .out_row      (out_row),
        .out_col      (out_col),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    assign credit_return = auto_ret ? out_valid : man_ret;

    typedef struct {
        int           due;
        logic [W-1:0] r;
        logic [W-1:0] c;
    } item_t;

    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    item_t          sb[$];
    int             fetch_cyc[$];
    logic [2*W-1:0] outs[$];
    int             ndone = 0;
    int             done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit    exp_ov, exp_me;
        item_t it;
        if (rst) begin
            sb.delete();
        end else begin
            exp_ov = (sb.size() > 0) && (sb[0].due == cyc);
            if (exp_ov || out_valid !== 1'b0) begin
                total++;
                if (out_valid !== exp_ov) begin
                    bad++;
                    $display("FAIL out_valid: got %b want %b at cycle %0d", out_valid, exp_ov, cyc);
                end
            end
            if (exp_ov) begin
                it = sb.pop_front();
                total++;
                if ({out_row, out_col} !== {it.r, it.c}) begin
                    bad++;
                    $display("FAIL out_tag: got (%0d,%0d) want (%0d,%0d) at cycle %0d",
                             out_row, out_col, it.r, it.c, cyc);
                end
            end
            if (out_valid === 1'b1) outs.push_back({out_row, out_col});
            exp_me = (sb.size() > 0) && (sb[0].due == cyc + 1);
            if (exp_me || mac_enable !== 1'b0) begin
                total++;
                if (mac_enable !== exp_me) begin
                    bad++;
                    $display("FAIL mac_enable: got %b want %b at cycle %0d", mac_enable, exp_me, cyc);
                end
            end
            if (fetch_valid === 1'b1) begin
                fetch_cyc.push_back(cyc);
                if (!abort) sb.push_back('{due: cyc + L, r: fetch_row, c: fetch_col});
            end
            // Abort empties the pipes at the coming edge, including this cycle's fetch.
            if (abort) sb.delete();
            if (done === 1'b1) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        fetch_cyc.delete();
        outs.delete();
        ndone = 0;
        done_cyc = 0;
    endtask

    task automatic run_image(input int w, input int h, input int bound, output bit ok);
        cfg_width = W'(w);
        cfg_height = W'(h);
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (ndone != 0) break;
            tick();
        end
        ok = (ndone != 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({fetch_valid, mac_enable, out_valid, busy, done, cfg_err, credit_err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {fetch_valid, mac_enable, out_valid, busy, done, cfg_err, credit_err});
        end
        total++;
        if ({fetch_row, fetch_col, out_row, out_col} !== '0) begin
            bad++;
            $display("FAIL reset_fields: got %h want 0", {fetch_row, fetch_col, out_row, out_col});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int exp_rel[6] = '{0, 1, 2, 3, 5, 6};
        int exp_r[6] = '{0, 0, 0, 1, 1, 1};
        int exp_c[6] = '{0, 1, 2, 0, 1, 2};
        auto_ret = 1'b1;
        run_image(5, 4, 200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_done: got timeout want done"); end
        total++;
        if (fetch_cyc.size() != 6) begin
            bad++;
            $display("FAIL basic_fetches: got %0d want 6", fetch_cyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (fetch_cyc[i] - fetch_cyc[0] != exp_rel[i]) begin
                    bad++;
                    $display("FAIL basic_issue_slot%0d: got %0d want %0d", i,
                             fetch_cyc[i] - fetch_cyc[0], exp_rel[i]);
                end
            end
            total++;
            if (done_cyc - fetch_cyc[5] != L + 1) begin
                bad++;
                $display("FAIL basic_done_lat: got %0d want %0d", done_cyc - fetch_cyc[5], L + 1);
            end
        end
        total++;
        if (outs.size() != 6) begin
            bad++;
            $display("FAIL basic_results: got %0d want 6", outs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (outs[i] !== {W'(exp_r[i]), W'(exp_c[i])}) begin
                    bad++;
                    $display("FAIL basic_order%0d: got %h want (%0d,%0d)", i, outs[i], exp_r[i],
                             exp_c[i]);
                end
            end
        end
        total++;
        if (busy !== 1'b0 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: got busy=%b cfg_err=%b want 0 0", busy, cfg_err);
        end
        tick();
    endtask

    task automatic test_credit_stall();
        auto_ret = 1'b0;
        man_ret = 1'b0;
        cfg_width = W'(6);
        cfg_height = W'(6);
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        total++;
        if (fetch_cyc.size() != CR) begin
            bad++;
            $display("FAIL stall_fetches: got %0d want %0d", fetch_cyc.size(), CR);
        end
        total++;
        if (fetch_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_state: got fv=%b busy=%b want 0 1", fetch_valid, busy);
        end
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        total++;
        if (fetch_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: got %b want 1", fetch_valid);
        end
        repeat (3) tick();
        total++;
        if (fetch_cyc.size() != CR + 1) begin
            bad++;
            $display("FAIL stall_one_more: got %0d want %0d", fetch_cyc.size(), CR + 1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || credit_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_abort: got busy=%b credit_err=%b want 0 0", busy, credit_err);
        end
        tick();
    endtask

    task automatic test_coincident();
        bit ok;
        int exp_rel[8] = '{0, 1, 2, 3, 5, 6, 7, 8};
        auto_ret = 1'b1;
        run_image(10, 3, 200, ok);
        total++;
        if (!ok || fetch_cyc.size() != 8) begin
            bad++;
            $display("FAIL coin_run: got ok=%b fetches=%0d want 1 8", ok, fetch_cyc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (fetch_cyc[i] - fetch_cyc[0] != exp_rel[i]) begin
                    bad++;
                    $display("FAIL coin_slot%0d: got %0d want %0d", i,
                             fetch_cyc[i] - fetch_cyc[0], exp_rel[i]);
                end
            end
        end
        tick();
        auto_ret = 1'b0;
        man_ret = 1'b1;
        tick();
        man_ret = 1'b0;
        tick();
        total++;
        if (credit_err !== 1'b1) begin
            bad++;
            $display("FAIL coin_credit_err: got %b want 1", credit_err);
        end
        cfg_width = W'(6);
        cfg_height = W'(6);
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (credit_err !== 1'b0) begin
            bad++;
            $display("FAIL coin_err_clear: got %b want 0", credit_err);
        end
        repeat (12) tick();
        total++;
        if (fetch_cyc.size() != CR) begin
            bad++;
            $display("FAIL coin_saturate: got %0d want %0d", fetch_cyc.size(), CR);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_cfg_err();
        bit ok;
        auto_ret = 1'b0;
        cfg_width = W'(2);
        cfg_height = W'(10);
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({cfg_err, done, busy} !== 3'b110) begin
            bad++;
            $display("FAIL cfg_bad: got err/done/busy=%b want 110", {cfg_err, done, busy});
        end
        repeat (3) tick();
        total++;
        if (fetch_cyc.size() != 0 || busy !== 1'b0 || cfg_err !== 1'b1 || ndone != 1) begin
            bad++;
            $display("FAIL cfg_quiet: got fetches=%0d busy=%b err=%b dones=%0d want 0 0 1 1",
                     fetch_cyc.size(), busy, cfg_err, ndone);
        end
        auto_ret = 1'b1;
        run_image(5, 4, 200, ok);
        total++;
        if (!ok || cfg_err !== 1'b0 || fetch_cyc.size() != 6) begin
            bad++;
            $display("FAIL cfg_recover: got ok=%b err=%b fetches=%0d want 1 0 6", ok, cfg_err,
                     fetch_cyc.size());
        end
        tick();
    endtask

    task automatic test_abort();
        bit ok;
        auto_ret = 1'b0;
        cfg_width = W'(6);
        cfg_height = W'(6);
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if ({out_valid, mac_enable, busy, fetch_valid, done} !== 5'b0) begin
            bad++;
            $display("FAIL abort_outputs: got %b want 00000",
                     {out_valid, mac_enable, busy, fetch_valid, done});
        end
        total++;
        if (fetch_cyc.size() != 3) begin
            bad++;
            $display("FAIL abort_inflight: got %0d want 3", fetch_cyc.size());
        end
        repeat (6) tick();
        total++;
        if (ndone != 0 || outs.size() != 0) begin
            bad++;
            $display("FAIL abort_quiet: got dones=%0d results=%0d want 0 0", ndone, outs.size());
        end
        auto_ret = 1'b1;
        run_image(5, 4, 200, ok);
        total++;
        if (!ok || fetch_cyc.size() != 6) begin
            bad++;
            $display("FAIL abort_rerun: got ok=%b fetches=%0d want 1 6", ok, fetch_cyc.size());
        end else begin
            total++;
            if (fetch_cyc[4] - fetch_cyc[0] != 5) begin
                bad++;
                $display("FAIL abort_credits: got slot %0d want 5", fetch_cyc[4] - fetch_cyc[0]);
            end
        end
        tick();
    endtask

    task automatic test_rst_drain();
        bit ok;
        auto_ret = 1'b1;
        cfg_width = W'(5);
        cfg_height = W'(4);
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (fetch_cyc.size() >= 6) break;
            tick();
        end
        total++;
        if (fetch_cyc.size() != 6) begin
            bad++;
            $display("FAIL rst_setup: got %0d want 6", fetch_cyc.size());
        end
        tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, mac_enable, busy, fetch_valid, done} !== 5'b0 || ndone != 0) begin
            bad++;
            $display("FAIL rst_async: got %b dones=%0d want 00000 0",
                     {out_valid, mac_enable, busy, fetch_valid, done}, ndone);
        end
        tick();
        rst = 1'b0;
        tick();
        run_image(5, 4, 200, ok);
        total++;
        if (!ok || fetch_cyc.size() != 6 || outs.size() != 6) begin
            bad++;
            $display("FAIL rst_rerun: got ok=%b fetches=%0d results=%0d want 1 6 6", ok,
                     fetch_cyc.size(), outs.size());
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        auto_ret = 1'b0;
        man_ret = 1'b0;
        cfg_width = '0;
        cfg_height = '0;
        test_reset();
        test_basic();
        test_credit_stall();
        test_coincident();
        test_cfg_err();
        test_abort();
        test_rst_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
